// File: rtl/sha_pkg.sv
// Shared SHA-256 message types: one 32-bit word and the 16-word history window
// (index 0 = newest word, index 15 = oldest).
package sha_pkg;

  localparam int WORDS_PER_BLOCK = 16;
  localparam int WORD_WIDTH      = 32;

  typedef logic [WORD_WIDTH-1:0] word_t;
  typedef word_t [WORDS_PER_BLOCK-1:0] window_t;

endpackage

// File: rtl/message_window_shift.sv
// 16-word shift register: new words enter at index 0 and age toward index 15.
// A parallel load takes priority over shifting.
module message_window_shift
  import sha_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    en,
  input  logic    load,
  input  window_t load_data,
  input  word_t   shift_in,
  output window_t window
);

  window_t window_r;

  // Window storage: load, shift in the newest word, or hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      window_r <= '0;
    end else if (load) begin
      window_r <= load_data;
    end else if (en) begin
      window_r <= {window_r[WORDS_PER_BLOCK-2:0], shift_in};
    end else begin
      window_r <= window_r;
    end
  end

  assign window = window_r;

endmodule

// File: rtl/message_block_loader.sv
// Assembles streamed message words into 16-word blocks and hands them to the
// expander through a double-buffered valid/ready output stage.
module message_block_loader
  import sha_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  word_t       word_i,
  input  logic        word_valid_i,
  output logic        word_ready_o,
  input  logic        flush_i,
  output window_t     W_o,
  output logic        block_valid_o,
  input  logic        block_ready_i,
  output logic [4:0]  fill_count_o,
  output logic [31:0] block_count_o
);

  localparam logic [4:0] FILL_FULL = 5'(WORDS_PER_BLOCK);

  logic [4:0]  fill_count_r;
  logic        block_valid_r;
  window_t     window_r;
  logic [31:0] block_count_r;
  window_t     fill_window_s;

  logic full_s;
  logic transfer_s;
  logic ready_s;
  logic handoff_s;
  logic accept_s;

  // Handshake decode; flush masks every event so nothing moves that cycle.
  always_comb begin
    full_s     = (fill_count_r == FILL_FULL);
    transfer_s = 1'b0;
    ready_s    = 1'b0;
    handoff_s  = 1'b0;
    if (flush_i) begin
      transfer_s = 1'b0;
      ready_s    = 1'b0;
      handoff_s  = 1'b0;
    end else begin
      transfer_s = full_s && (!block_valid_r || block_ready_i);
      ready_s    = !full_s || transfer_s;
      handoff_s  = block_valid_r && block_ready_i;
    end
    accept_s = word_valid_i && ready_s;
  end

  message_window_shift u_fill (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (accept_s),
    .load      (flush_i),
    .load_data ('0),
    .shift_in  (word_i),
    .window    (fill_window_s)
  );

  // Fill occupancy; a word accepted during a transfer starts the next block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_count_r <= 5'd0;
    end else if (flush_i) begin
      fill_count_r <= 5'd0;
    end else if (transfer_s) begin
      fill_count_r <= accept_s ? 5'd1 : 5'd0;
    end else if (accept_s) begin
      fill_count_r <= fill_count_r + 5'd1;
    end else begin
      fill_count_r <= fill_count_r;
    end
  end

  // Output block register and its valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      window_r      <= '0;
      block_valid_r <= 1'b0;
    end else if (flush_i) begin
      window_r      <= window_r;
      block_valid_r <= 1'b0;
    end else if (transfer_s) begin
      window_r      <= fill_window_s;
      block_valid_r <= 1'b1;
    end else if (handoff_s) begin
      window_r      <= window_r;
      block_valid_r <= 1'b0;
    end else begin
      window_r      <= window_r;
      block_valid_r <= block_valid_r;
    end
  end

  // Handed-off block counter, wrapping modulo 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      block_count_r <= 32'd0;
    end else if (handoff_s) begin
      block_count_r <= block_count_r + 32'd1;
    end else begin
      block_count_r <= block_count_r;
    end
  end

  assign word_ready_o  = ready_s;
  assign W_o           = window_r;
  assign block_valid_o = block_valid_r;
  assign fill_count_o  = fill_count_r;
  assign block_count_o = block_count_r;

endmodule

// File: tb/tb_message_block_loader.sv
// Directed self-checking bench for message_block_loader.
module tb_message_block_loader;
  import sha_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  word_t       word_i = 32'd0;
  logic        word_valid_i = 1'b0;
  logic        word_ready_o;
  logic        flush_i = 1'b0;
  window_t     W_o;
  logic        block_valid_o;
  logic        block_ready_i = 1'b0;
  logic [4:0]  fill_count_o;
  logic [31:0] block_count_o;

  int err_cnt = 0;
  int chk_cnt = 0;
  int stall_cnt = 0;
  window_t blk_q[$];
  word_t hold_hi;
  word_t hold_lo;

  message_block_loader dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .word_i        (word_i),
    .word_valid_i  (word_valid_i),
    .word_ready_o  (word_ready_o),
    .flush_i       (flush_i),
    .W_o           (W_o),
    .block_valid_o (block_valid_o),
    .block_ready_i (block_ready_i),
    .fill_count_o  (fill_count_o),
    .block_count_o (block_count_o)
  );

  always #5 clk = ~clk;

  // Collect every block the consumer actually takes.
  always @(negedge clk) begin
    if (rst_n && block_valid_o && block_ready_i && !flush_i) blk_q.push_back(W_o);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic push_word(input word_t d);
    int n;
    n = 0;
    @(posedge clk); #1;
    word_i = d;
    word_valid_i = 1'b1;
    #1;
    while (!word_ready_o && n < 40) begin
      stall_cnt++;
      n++;
      @(posedge clk); #2;
    end
    if (n >= 40) check("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    word_valid_i = 1'b0;
  endtask

  task automatic push_block(input word_t base);
    for (int i = 1; i <= 16; i++) push_word(base + word_t'(i));
  endtask

  task automatic check_block(input string tag, input window_t w, input word_t base);
    for (int j = 0; j < 16; j++) check(tag, w[15-j], base + word_t'(j + 1));
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_fill", 32'(fill_count_o), 32'd0);
    check("rst_valid", 32'(block_valid_o), 32'd0);
    check("rst_count", block_count_o, 32'd0);
    check("rst_w_zero", 32'(|W_o), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_ready", 32'(word_ready_o), 32'd1);

    // Single block with 2-cycle latency and a one-cycle valid pulse
    block_ready_i = 1'b1;
    push_block(32'h0000_0000);
    idle();
    @(negedge clk);
    check("t1_fill16", 32'(fill_count_o), 32'd16);
    check("t1_valid_t1", 32'(block_valid_o), 32'd0);
    @(negedge clk);
    check("t1_valid_t2", 32'(block_valid_o), 32'd1);
    check("t1_w15", W_o[15], 32'h0000_0001);
    check("t1_w0", W_o[0], 32'h0000_0010);
    check("t1_fill0", 32'(fill_count_o), 32'd0);
    @(negedge clk);
    check("t1_valid_drop", 32'(block_valid_o), 32'd0);
    check("t1_count", block_count_o, 32'd1);

    // Back-to-back: 48 words with no stalls
    blk_q.delete();
    stall_cnt = 0;
    push_block(32'h0000_0100);
    push_block(32'h0000_0110);
    push_block(32'h0000_0120);
    idle();
    repeat (4) @(negedge clk);
    check("t2_stalls", 32'(stall_cnt), 32'd0);
    check("t2_nblocks", 32'(blk_q.size()), 32'd3);
    if (blk_q.size() == 3) begin
      check_block("t2_blk0", blk_q[0], 32'h0000_0100);
      check_block("t2_blk1", blk_q[1], 32'h0000_0110);
      check_block("t2_blk2", blk_q[2], 32'h0000_0120);
    end
    check("t2_count", block_count_o, 32'd4);

    // Backpressure: output held, fill buffer stalls full
    blk_q.delete();
    block_ready_i = 1'b0;
    push_block(32'h0000_0200);
    push_block(32'h0000_0210);
    idle();
    @(negedge clk);
    check("t3_fill16", 32'(fill_count_o), 32'd16);
    check("t3_ready0", 32'(word_ready_o), 32'd0);
    check("t3_valid", 32'(block_valid_o), 32'd1);
    hold_hi = W_o[15];
    hold_lo = W_o[0];
    check("t3_w15", hold_hi, 32'h0000_0201);
    check("t3_w0", hold_lo, 32'h0000_0210);
    repeat (3) @(negedge clk);
    check("t3_stable15", W_o[15], 32'h0000_0201);
    check("t3_stable0", W_o[0], 32'h0000_0210);
    check("t3_count_held", block_count_o, 32'd4);
    @(posedge clk); #1;
    block_ready_i = 1'b1;
    repeat (4) @(negedge clk);
    check("t3_nblocks", 32'(blk_q.size()), 32'd2);
    if (blk_q.size() == 2) begin
      check_block("t3_blk0", blk_q[0], 32'h0000_0200);
      check_block("t3_blk1", blk_q[1], 32'h0000_0210);
    end
    check("t3_count", block_count_o, 32'd6);

    // Flush mid-fill
    for (int i = 1; i <= 7; i++) push_word(32'h0000_0500 + word_t'(i));
    @(posedge clk); #1;
    word_valid_i = 1'b0;
    flush_i = 1'b1;
    #1;
    check("t4_ready_flush", 32'(word_ready_o), 32'd0);
    @(posedge clk); #1;
    flush_i = 1'b0;
    @(negedge clk);
    check("t4_fill0", 32'(fill_count_o), 32'd0);
    blk_q.delete();
    push_block(32'h0000_0300);
    idle();
    repeat (4) @(negedge clk);
    check("t4_nblocks", 32'(blk_q.size()), 32'd1);
    if (blk_q.size() == 1) check_block("t4_blk", blk_q[0], 32'h0000_0300);
    check("t4_count", block_count_o, 32'd7);

    // Flush with a held block and coincident block_ready_i
    block_ready_i = 1'b0;
    push_block(32'h0000_0400);
    idle();
    repeat (3) @(negedge clk);
    check("t5_valid_held", 32'(block_valid_o), 32'd1);
    @(posedge clk); #1;
    flush_i = 1'b1;
    block_ready_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    block_ready_i = 1'b0;
    @(negedge clk);
    check("t5_valid0", 32'(block_valid_o), 32'd0);
    check("t5_count", block_count_o, 32'd7);
    check("t5_fill0", 32'(fill_count_o), 32'd0);

    // Asynchronous reset mid-cycle during a fill
    for (int i = 1; i <= 5; i++) push_word(32'h0000_0600 + word_t'(i));
    @(posedge clk); #1;
    word_valid_i = 1'b0;
    check("t6_fill5", 32'(fill_count_o), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_fill", 32'(fill_count_o), 32'd0);
    check("t6_valid", 32'(block_valid_o), 32'd0);
    check("t6_count", block_count_o, 32'd0);
    check("t6_w_zero", 32'(|W_o), 32'd0);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_ready", 32'(word_ready_o), 32'd1);
    check("t6_fill_after", 32'(fill_count_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
